// File: rtl/uart_tx_stream_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// No logic; elaboration-time definitions only.
// Not applicable.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;

    // Serial bit periods in one frame: start + data + optional parity + stops.
    function automatic int frame_bits(input int data_bits, input int parity_mode,
                                      input int stop_bits);
        return 1 + data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready word stream feeding the UART transmitter.
// Combinational bundle, no latency.
// Slave drops s_ready while it cannot accept; master holds s_valid/s_data.
interface uart_tx_stream_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_stream_fifo.sv
// Single-clock FIFO with level output and fall-through head read.
// Write visible in level/empty one cycle after the write edge; read data combinational.
// Writes ignored while full, reads ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, configurable width/parity/stops.
// Word accepted into an idle, empty unit reaches tx two edges later; frames back-to-back.
// s_ready = !full; a pop frees a slot that shows on s_ready the following cycle.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_stream_if.slave               s,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int      CW  = $clog2(CLKS_PER_BIT);
    localparam int      BW  = $clog2(DATA_BITS + 1);
    localparam parity_e PAR = parity_e'(2'(PARITY_MODE));

    uart_tx_state_e       state;
    uart_tx_state_e       state_nx;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_nx;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    logic                 baud_wrap;
    logic                 last_data;
    logic                 last_stop;

    assign push      = s.s_valid && !fifo_full;
    assign s.s_ready = !fifo_full;
    assign tx_busy   = (state != ST_IDLE) || !fifo_empty;

    assign baud_wrap = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (s.s_data),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Next state, pop decision and the line value for the current bit.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        tx_nx    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                tx_nx = 1'b0;
                if (baud_wrap) state_nx = ST_DATA;
            end
            ST_DATA: begin
                tx_nx = shreg[0];
                if (baud_wrap && last_data)
                    state_nx = (PAR == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                tx_nx = par_bit;
                if (baud_wrap) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (baud_wrap && last_stop) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = ST_START;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register and registered line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tx    <= 1'b1;
        end else begin
            state <= state_nx;
            tx    <= tx_nx;
        end
    end

    // Baud and bit counters; bit counter restarts whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state == ST_IDLE || baud_wrap) baud_cnt <= '0;
            else                               baud_cnt <= baud_cnt + 1'b1;

            if (state != state_nx)
                bit_cnt <= '0;
            else if (baud_wrap && (state == ST_DATA || state == ST_STOP))
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Shift register loads the popped head word; parity is fixed at load time.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (pop) begin
            shreg   <= head;
            par_bit <= (PAR == PAR_ODD) ? ~^head : ^head;
        end else if (state == ST_DATA && baud_wrap) begin
            shreg   <= shreg >> 1;
        end
    end
endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream across several parameter sets.
// Exact per-cycle frame vectors plus mid-bit decoding of streamed words.
// Exercises full-FIFO backpressure and reset during a frame.
module tb_uart_tx_stream;

    localparam int N = 7;

    logic       clk;
    logic       sv     [N];
    logic [8:0] sd     [N];
    logic       rst_w  [N];
    logic       tx_w   [N];
    logic       busy_w [N];
    logic       rdy_w  [N];
    logic [2:0] lvl_w  [N];

    int cpb [N] = '{4, 4, 4, 4, 2, 2, 2};
    int dbs [N] = '{8, 8, 8, 7, 9, 5, 8};
    int pms [N] = '{0, 1, 2, 0, 2, 1, 0};
    int sbs [N] = '{1, 1, 1, 2, 2, 1, 1};

    int checks = 0;
    int errors = 0;

    logic [8:0] words [8];
    logic       seen_full;

    typedef struct {
        int          inst;
        logic [8:0]  d0;
        logic [8:0]  d1;
        logic        two;
        int          nbits;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_stream_if #(.DATA_BITS(8)) if0 ();
    uart_tx_stream_if #(.DATA_BITS(8)) if1 ();
    uart_tx_stream_if #(.DATA_BITS(8)) if2 ();
    uart_tx_stream_if #(.DATA_BITS(7)) if3 ();
    uart_tx_stream_if #(.DATA_BITS(9)) if4 ();
    uart_tx_stream_if #(.DATA_BITS(5)) if5 ();
    uart_tx_stream_if #(.DATA_BITS(8)) if6 ();

    assign if0.s_valid = sv[0]; assign if0.s_data = sd[0][7:0]; assign rdy_w[0] = if0.s_ready;
    assign if1.s_valid = sv[1]; assign if1.s_data = sd[1][7:0]; assign rdy_w[1] = if1.s_ready;
    assign if2.s_valid = sv[2]; assign if2.s_data = sd[2][7:0]; assign rdy_w[2] = if2.s_ready;
    assign if3.s_valid = sv[3]; assign if3.s_data = sd[3][6:0]; assign rdy_w[3] = if3.s_ready;
    assign if4.s_valid = sv[4]; assign if4.s_data = sd[4][8:0]; assign rdy_w[4] = if4.s_ready;
    assign if5.s_valid = sv[5]; assign if5.s_data = sd[5][4:0]; assign rdy_w[5] = if5.s_ready;
    assign if6.s_valid = sv[6]; assign if6.s_data = sd[6][7:0]; assign rdy_w[6] = if6.s_ready;

    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u0 (.clk(clk), .rst(rst_w[0]), .s(if0), .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_level(lvl_w[0]));
    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u1 (.clk(clk), .rst(rst_w[1]), .s(if1), .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_level(lvl_w[1]));
    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u2 (.clk(clk), .rst(rst_w[2]), .s(if2), .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_level(lvl_w[2]));
    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u3 (.clk(clk), .rst(rst_w[3]), .s(if3), .tx(tx_w[3]), .tx_busy(busy_w[3]), .fifo_level(lvl_w[3]));
    uart_tx_stream #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4))
        u4 (.clk(clk), .rst(rst_w[4]), .s(if4), .tx(tx_w[4]), .tx_busy(busy_w[4]), .fifo_level(lvl_w[4]));
    uart_tx_stream #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u5 (.clk(clk), .rst(rst_w[5]), .s(if5), .tx(tx_w[5]), .tx_busy(busy_w[5]), .fifo_level(lvl_w[5]));
    uart_tx_stream #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u6 (.clk(clk), .rst(rst_w[6]), .s(if6), .tx(tx_w[6]), .tx_busy(busy_w[6]), .fifo_level(lvl_w[6]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Mid-bit decoder for one frame on instance i.
    task automatic decode(input int i, output logic [8:0] d, output logic par,
                          output logic [1:0] stp, output logic st, output logic tmo);
        int n;
        d = '0; par = 1'b0; stp = 2'b11; st = 1'b1; tmo = 1'b0;
        n = 0;
        while (tx_w[i] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tmo = 1'b1;
        end else begin
            repeat ((cpb[i] - 1) / 2) @(negedge clk);
            st = tx_w[i];
            for (int b = 0; b < dbs[i]; b++) begin
                repeat (cpb[i]) @(negedge clk);
                d[b] = tx_w[i];
            end
            if (pms[i] != 0) begin
                repeat (cpb[i]) @(negedge clk);
                par = tx_w[i];
            end
            for (int k = 0; k < sbs[i]; k++) begin
                repeat (cpb[i]) @(negedge clk);
                stp[k] = tx_w[i];
            end
        end
    endtask

    task automatic check_frame(input int i, input logic [8:0] expd);
        logic [8:0] d, m, mask;
        logic       par, st, tmo, ep;
        logic [1:0] stp;
        decode(i, d, par, stp, st, tmo);
        mask = 9'((1 << dbs[i]) - 1);
        m    = expd & mask;
        ep   = (pms[i] == 1) ? ^m : ~^m;
        check("frame_timeout", {31'd0, tmo}, 32'd0);
        check("start_bit", {31'd0, st}, 32'd0);
        check("data_word", {23'd0, d}, {23'd0, m});
        if (pms[i] != 0) check("parity_bit", {31'd0, par}, {31'd0, ep});
        check("stop_bits", {30'd0, stp}, 32'd3);
    endtask

    // Hold s_valid and push words[0..n-1]; entered and left on a negedge.
    task automatic push_hold(input int i, input int n, input logic chk);
        int  w;
        logic blocked;
        for (int k = 0; k < n; k++) begin
            sd[i] = words[k];
            sv[i] = 1'b1;
            w = 0;
            blocked = 1'b0;
            while (rdy_w[i] !== 1'b1 && w < 400) begin
                if (chk && !seen_full) begin
                    check("full_level", {29'd0, lvl_w[i]}, 32'd4);
                    seen_full = 1'b1;
                end
                blocked = 1'b1;
                @(negedge clk);
                w++;
            end
            check("push_wait_bound", {31'd0, (w < 400)}, 32'd1);
            if (chk && blocked) check("ready_back_level", {29'd0, lvl_w[i]}, 32'd3);
            @(posedge clk);
            @(negedge clk);
        end
        sv[i] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{inst: 0, d0: 9'h0A5, d1: 9'h000, two: 1'b0, nbits: 10, exp: 32'b1101001010};
        vecs[1] = '{inst: 1, d0: 9'h007, d1: 9'h000, two: 1'b0, nbits: 11, exp: 32'b11000001110};
        vecs[2] = '{inst: 2, d0: 9'h007, d1: 9'h000, two: 1'b0, nbits: 11, exp: 32'b10000001110};
        vecs[3] = '{inst: 3, d0: 9'h055, d1: 9'h02A, two: 1'b1, nbits: 20,
                    exp: {12'd0, 10'b1101010100, 10'b1110101010}};
        vecs[4] = '{inst: 0, d0: 9'h03C, d1: 9'h000, two: 1'b0, nbits: 10, exp: 32'b1001111000};
        vecs[5] = '{inst: 1, d0: 9'h0FE, d1: 9'h000, two: 1'b0, nbits: 11, exp: 32'b11111111100};

        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b0; sd[i] = '0; rst_w[i] = 1'b1;
        end
        seen_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset_tx",    {31'd0, tx_w[i]},   32'd1);
            check("reset_busy",  {31'd0, busy_w[i]}, 32'd0);
            check("reset_ready", {31'd0, rdy_w[i]},  32'd1);
            check("reset_level", {29'd0, lvl_w[i]},  32'd0);
            rst_w[i] = 1'b0;
        end
        @(negedge clk);

        // Exact per-cycle frame vectors.
        for (int v = 0; v < 6; v++) begin
            int i;
            int bad;
            i = vecs[v].inst;
            sd[i] = vecs[v].d0;
            sv[i] = 1'b1;
            @(negedge clk);
            if (vecs[v].two) sd[i] = vecs[v].d1;
            else             sv[i] = 1'b0;
            @(negedge clk);
            sv[i] = 1'b0;
            check("latency_idle_high", {31'd0, tx_w[i]}, 32'd1);
            for (int b = 0; b < vecs[v].nbits; b++) begin
                bad = 0;
                for (int c = 0; c < cpb[i]; c++) begin
                    @(negedge clk);
                    if (tx_w[i] !== vecs[v].exp[b]) bad++;
                end
                check($sformatf("vec%0d_bit%0d_wrong_cycles", v, b), bad, 0);
                if (b == 1) check("busy_mid_frame", {31'd0, busy_w[i]}, 32'd1);
            end
            @(negedge clk);
            check("after_frame_tx",   {31'd0, tx_w[i]},   32'd1);
            check("after_frame_busy", {31'd0, busy_w[i]}, 32'd0);
        end

        // Backpressure: six words with s_valid held, depth 4.
        words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033;
        words[3] = 9'h044; words[4] = 9'h055; words[5] = 9'h066;
        fork
            push_hold(0, 6, 1'b1);
            begin
                for (int k = 0; k < 6; k++) check_frame(0, words[k]);
            end
        join
        check("saw_full", {31'd0, seen_full}, 32'd1);
        repeat (4) @(negedge clk);
        check("bp_drained_level", {29'd0, lvl_w[0]}, 32'd0);

        // Reset in the middle of the 4th data bit with two words queued.
        sd[0] = 9'h081; sv[0] = 1'b1;
        @(negedge clk); sd[0] = 9'h042;
        @(negedge clk); sd[0] = 9'h024;
        @(negedge clk); sv[0] = 1'b0;
        check("queued_before_reset", {29'd0, lvl_w[0]}, 32'd2);
        repeat (16) @(negedge clk);
        rst_w[0] = 1'b1;
        @(negedge clk);
        rst_w[0] = 1'b0;
        check("rst_mid_tx",    {31'd0, tx_w[0]},   32'd1);
        check("rst_mid_busy",  {31'd0, busy_w[0]}, 32'd0);
        check("rst_mid_level", {29'd0, lvl_w[0]},  32'd0);
        begin
            int lows;
            lows = 0;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lows++;
            end
            check("quiet_after_reset", lows, 0);
        end
        sd[0] = 9'h05A; sv[0] = 1'b1;
        @(negedge clk); sv[0] = 1'b0;
        check_frame(0, 9'h05A);

        // Minimum bit period, random data in every parity mode.
        for (int i = 4; i < 7; i++) begin
            for (int k = 0; k < 8; k++) words[k] = 9'($urandom_range(0, 511));
            @(negedge clk);
            fork
                push_hold(i, 8, 1'b0);
                begin
                    for (int k = 0; k < 8; k++) check_frame(i, words[k]);
                end
            join
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
